// File: rtl/cpu_pkg.sv
// Shared types and constants for the 16-bit pipelined CPU.
// Word width, opcode encodings, reset vector and the fetch->decode bundle.
package cpu_pkg;

    localparam int WORD_W = 16;

    localparam logic [1:0] OP_ALU = 2'b00;
    localparam logic [1:0] OP_LI  = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    typedef logic [WORD_W-1:0] word_t;

    localparam word_t DEF_RESET_PC = 16'h0000;

    typedef struct packed {
        word_t ir;
        word_t pc;
    } if_id_t;

    // Encoded as {request outstanding, discard response}
    typedef enum logic [1:0] {
        FS_IDLE = 2'b00,
        FS_WAIT = 2'b10,
        FS_DISC = 2'b11
    } fetch_state_e;

endpackage

// File: rtl/ifetch_fifo.sv
// Small power-of-two FIFO with flush and a combinational head read.
// The head holds the last presented entry while the FIFO is empty.
module ifetch_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 32,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count,
    output logic          empty
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [W-1:0]  last_q;
    logic          full;
    logic          do_pop;
    logic          do_push;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? last_q : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            last_q <= '0;
        end else begin
            if (!empty) last_q <= mem[rd_ptr];
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + 1'b1;
                if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
                count <= count + CW'(do_push) - CW'(do_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch front end: one outstanding imem request, a prefetch
// queue of {ir, pc} and branch redirect with wrong-path response discard.
module ifetch_unit
    import cpu_pkg::*;
#(
    parameter int    DEPTH    = 2,
    parameter word_t RESET_PC = DEF_RESET_PC
) (
    input  logic              CLK,
    input  logic              RSTN,
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [WORD_W-1:0] imem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_ir,
    output logic [WORD_W-1:0] out_pc,
    input  logic              br_taken,
    input  logic [WORD_W-1:0] br_target
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e  state_q;
    fetch_state_e  state_d;
    word_t         addr_q;
    word_t         addr_d;
    word_t         fetch_q;
    word_t         fetch_d;
    word_t         tgt;
    logic          discard;
    logic          acked;
    logic          busy;
    logic          push;
    logic          pop;
    logic          room;
    logic          q_empty;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nx;
    if_id_t        wentry;
    if_id_t        head;

    assign imem_req  = (state_q != FS_IDLE);
    assign discard   = (state_q == FS_DISC);
    assign imem_addr = addr_q;
    assign out_valid = !q_empty;
    assign out_ir    = head.ir;
    assign out_pc    = head.pc;

    assign acked = imem_req && imem_ack;
    assign busy  = imem_req && !imem_ack;
    assign push  = acked && !discard && !br_taken;
    assign pop   = out_valid && out_ready && !br_taken;
    assign tgt   = br_taken ? br_target : fetch_q;

    // Occupancy after this edge decides whether a new request fits
    assign count_nx = br_taken ? '0 : count + CW'(push) - CW'(pop);
    assign room     = (count_nx < CW'(DEPTH));

    assign wentry = '{ir: imem_rdata, pc: addr_q};

    ifetch_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(if_id_t))
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RSTN),
        .push  (push),
        .pop   (pop),
        .flush (br_taken),
        .wdata (wentry),
        .head  (head),
        .count (count),
        .empty (q_empty)
    );

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= FS_IDLE;
            addr_q  <= RESET_PC;
            fetch_q <= RESET_PC;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            fetch_q <= fetch_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        fetch_d = tgt;
        unique case (1'b1)
            (!busy && room): begin
                state_d = FS_WAIT;
                addr_d  = tgt;
                fetch_d = tgt + 16'd1;
            end
            busy: begin
                // Held request stays on the bus; a redirect marks it stale
                state_d = (discard || br_taken) ? FS_DISC : FS_WAIT;
            end
            default: begin
                state_d = FS_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: stream-order model plus directed cases.
// A second instance exercises address wrap and mid-request reset.
module tb_ifetch_unit;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_ir;
    logic [15:0] out_pc;
    logic        br_taken;
    logic [15:0] br_target;

    logic        RSTN2;
    logic        w_req;
    logic [15:0] w_addr;
    logic        w_ack;
    logic [15:0] w_rdata;
    logic        w_valid;
    logic        w_ready;
    logic [15:0] w_ir;
    logic [15:0] w_pc;
    logic        w_br;
    logic [15:0] w_tgt;

    int lat;
    int wait_cnt;
    int checks = 0;
    int errors = 0;
    int pops = 0;

    logic [15:0] exp_pc;
    logic [15:0] exp_fetch;
    logic [15:0] hold_addr;
    logic        pending;
    logic [15:0] exp_w [3] = '{16'hFFFE, 16'hFFFF, 16'h0000};

    always #5 CLK = ~CLK;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return (a == 16'h0000) ? 16'h7001 : (a ^ 16'hA5A5);
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    ifetch_unit dut (
        .CLK        (CLK),
        .RSTN       (RSTN),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ir     (out_ir),
        .out_pc     (out_pc),
        .br_taken   (br_taken),
        .br_target  (br_target)
    );

    ifetch_unit #(.DEPTH(2), .RESET_PC(16'hFFFE)) dut_wrap (
        .CLK        (CLK),
        .RSTN       (RSTN2),
        .imem_req   (w_req),
        .imem_addr  (w_addr),
        .imem_ack   (w_ack),
        .imem_rdata (w_rdata),
        .out_valid  (w_valid),
        .out_ready  (w_ready),
        .out_ir     (w_ir),
        .out_pc     (w_pc),
        .br_taken   (w_br),
        .br_target  (w_tgt)
    );

    // Memory models: main one has programmable wait states
    assign imem_ack   = imem_req && (wait_cnt == lat);
    assign imem_rdata = mem_word(imem_addr);
    assign w_ack      = w_req;
    assign w_rdata    = mem_word(w_addr);
    assign w_br       = 1'b0;
    assign w_tgt      = 16'h0000;

    always @(posedge CLK or negedge RSTN) begin
        if (!RSTN) wait_cnt <= 0;
        else if (!imem_req || imem_ack) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
    end

    // Reference model: program order of fetches and of delivered instructions
    always @(negedge CLK) begin
        if (!RSTN) begin
            exp_pc    = 16'h0000;
            exp_fetch = 16'h0000;
            pending   = 1'b0;
            hold_addr = 16'h0000;
        end else begin
            if (pending) begin
                chk("req_hold", imem_req, 1'b1);
                chk("addr_hold", imem_addr, hold_addr);
            end else if (imem_req) begin
                chk("fetch_addr", imem_addr, exp_fetch);
                exp_fetch = imem_addr + 16'd1;
            end
            pending   = imem_req && !imem_ack;
            hold_addr = imem_addr;
            if (out_valid && out_ready) begin
                chk("stream_pc", out_pc, exp_pc);
                chk("stream_ir", out_ir, mem_word(exp_pc));
                if (!br_taken) begin
                    exp_pc = exp_pc + 16'd1;
                    pops++;
                end
            end
            if (br_taken) begin
                exp_pc    = br_target;
                exp_fetch = br_target;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int k;
        int p0;
        RSTN      = 1'b0;
        RSTN2     = 1'b0;
        out_ready = 1'b0;
        w_ready   = 1'b1;
        br_taken  = 1'b0;
        br_target = 16'h0000;
        lat       = 0;
        tick();
        tick();
        chk("rst_req", imem_req, 1'b0);
        chk("rst_addr", imem_addr, 16'h0000);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_ir", out_ir, 16'h0000);
        chk("rst_pc", out_pc, 16'h0000);

        RSTN = 1'b1;
        tick();
        chk("first_req", imem_req, 1'b1);
        chk("first_addr", imem_addr, 16'h0000);
        chk("first_valid", out_valid, 1'b0);
        tick();
        chk("fill_valid", out_valid, 1'b1);
        chk("fill_ir", out_ir, 16'h7001);
        chk("fill_pc", out_pc, 16'h0000);

        repeat (5) tick();
        chk("bp_valid", out_valid, 1'b1);
        chk("bp_pc", out_pc, 16'h0000);
        chk("bp_req", imem_req, 1'b0);

        out_ready = 1'b1;
        repeat (3) tick();
        p0 = pops;
        repeat (10) tick();
        chk("throughput", pops - p0, 10);

        br_taken  = 1'b1;
        br_target = 16'h0100;
        chk("coinc_ack", imem_ack, 1'b1);
        chk("coinc_valid", out_valid, 1'b1);
        tick();
        br_taken = 1'b0;
        chk("redir_empty", out_valid, 1'b0);
        chk("redir_req", imem_req, 1'b1);
        chk("redir_addr", imem_addr, 16'h0100);
        tick();
        chk("redir_valid", out_valid, 1'b1);
        chk("redir_pc", out_pc, 16'h0100);
        repeat (5) tick();

        RSTN = 1'b0;
        #1;
        chk("midrst_req", imem_req, 1'b0);
        lat = 3;
        tick();
        RSTN = 1'b1;
        n = 0;
        while (!(imem_req && imem_addr == 16'h0002 && !imem_ack) && n < 200) begin
            tick();
            n++;
        end
        chk("slow_addr2_seen", n < 200, 1'b1);
        br_taken  = 1'b1;
        br_target = 16'h0008;
        tick();
        br_taken = 1'b0;
        chk("slow_hold_req", imem_req, 1'b1);
        chk("slow_hold_addr", imem_addr, 16'h0002);
        n = 0;
        while (!(imem_req && imem_addr == 16'h0008) && n < 200) begin
            tick();
            n++;
        end
        chk("slow_addr8_seen", n < 200, 1'b1);
        n = 0;
        while (!out_valid && n < 200) begin
            tick();
            n++;
        end
        chk("slow_valid_seen", n < 200, 1'b1);
        chk("slow_br_pc", out_pc, 16'h0008);

        n = 0;
        while (!(imem_req && wait_cnt == 0 && !imem_ack) && n < 200) begin
            tick();
            n++;
        end
        chk("b2b_start", n < 200, 1'b1);
        br_taken  = 1'b1;
        br_target = 16'h0030;
        tick();
        br_target = 16'h0050;
        tick();
        br_taken = 1'b0;
        n = 0;
        while (!out_valid && n < 200) begin
            tick();
            n++;
        end
        chk("b2b_valid_seen", n < 200, 1'b1);
        chk("b2b_pc", out_pc, 16'h0050);

        RSTN2 = 1'b1;
        k = 0;
        n = 0;
        while (k < 3 && n < 20) begin
            @(negedge CLK);
            if (w_valid) begin
                chk("wrap_pc", w_pc, exp_w[k]);
                chk("wrap_ir", w_ir, mem_word(exp_w[k]));
                k++;
            end
            n++;
        end
        chk("wrap_count", k, 3);

        @(posedge CLK);
        #3;
        chk("wrap_busy", w_req, 1'b1);
        RSTN2 = 1'b0;
        #1;
        chk("wrst_req", w_req, 1'b0);
        chk("wrst_addr", w_addr, 16'hFFFE);
        chk("wrst_valid", w_valid, 1'b0);
        tick();
        tick();
        RSTN2 = 1'b1;
        tick();
        chk("wrestart_req", w_req, 1'b1);
        chk("wrestart_addr", w_addr, 16'hFFFE);
        tick();
        chk("wrestart_valid", w_valid, 1'b1);
        chk("wrestart_pc", w_pc, 16'hFFFE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction-fetch front end of the 16-bit pipelined CPU; the producer side of the ir/pc interface consumed by the alu stage.
- Generates word addresses to instruction memory and buffers returned words in a small prefetch queue.
- Presents {ir, pc} pairs to decode/alu with a valid/ready handshake.
- Accepts taken-branch redirects (absolute target computed by the alu) and flushes wrong-path instructions.

Parameters:
- DEPTH, 2, prefetch queue entries (power of two, ≥2)
- RESET_PC, 16'h0000, first fetch address after reset

Ports:
- CLK  in  1  clock, rising edge
- RSTN  in  1  asynchronous active-low reset
- imem_req  out  1  fetch request, held until imem_ack
- imem_addr  out  16  word address, stable while imem_req high
- imem_ack  in  1  response valid this cycle (may arrive same cycle as request)
- imem_rdata  in  16  instruction word, valid with imem_ack
- out_valid  out  1  out_ir/out_pc hold a valid instruction
- out_ready  in  1  downstream accepts the instruction at this edge
- out_ir  out  16  instruction word (queue head)
- out_pc  out  16  word address of out_ir
- br_taken  in  1  redirect request, one-cycle pulse
- br_target  in  16  redirect address

Behaviour:
- Reset (asynchronous, any time): imem_req=0, imem_addr=RESET_PC, queue empty, out_valid=0, out_ir=0, out_pc=0, discard flag=0, fetch_pc=RESET_PC. Any in-flight memory response is forgotten.
- Addressing: word addresses; sequential next = fetch_pc+1, modulo 2^16 (16'hFFFF wraps to 0).
- Request issue:
  - imem_req is registered.
  - Asserted at an edge when: no request is outstanding or the current one is acked at that edge; and (queue count after this edge) + 1 ≤ DEPTH.
  - First request rises at the first edge with RSTN high.
- Request hold: once imem_req=1, imem_req and imem_addr stay unchanged until the edge where imem_ack=1. There is at most one outstanding request.
- Throughput: with zero-wait memory (ack in the request cycle) and out_ready held high, one instruction per cycle.
- Fill latency: out_valid rises one edge after the capturing ack.
- Queue:
  - FIFO of {ir, pc}. Push on a non-discarded ack; pop when out_valid && out_ready.
  - Push and pop in the same cycle are both performed; count is unchanged.
  - When full, no new request is issued.
  - out_* driven directly from head storage; out_ir/out_pc keep their last values while out_valid=0.
- Redirect (br_taken=1 at an edge):
  - Queue cleared; out_valid=0 next cycle. A pop in the same cycle is ignored.
  - fetch_pc <= br_target.
  - If imem_ack is in that same cycle, the response is dropped.
  - If a request is outstanding and not acked: imem_req/imem_addr stay held (protocol rule), the discard flag is set, and the eventual response is dropped and clears the flag. The first target fetch is issued at that ack edge.
  - If no request is outstanding: the request to br_target is issued at the redirect edge itself.
  - Back-to-back redirects: the latest br_target wins. The discard flag stays set until the single outstanding response returns.
- No other state machine. State is {idle, wait_ack, wait_ack_discard}, encoded as req + discard flag.

Decomposition:
- Shared package cpu_pkg: WORD_W=16; opcode constants OP_ALU=2'b00, OP_LI=2'b01, OP_BR=2'b10; RESET_PC default. The ifetch_unit itself does not decode instructions.
- One natural sub-module: ifetch_fifo, a parameterized DEPTH FIFO with push/pop/flush/count and head read. It is reused later for the writeback queue.

Test Plan:
- Reset/first fetch: RSTN=0 -> all outputs 0, imem_addr=0. Release with zero-wait memory returning rdata=16'h7001 for addr 0 -> imem_req=1 at first edge; out_valid=1, out_ir=16'h7001, out_pc=0 one edge later.
- Streaming: zero-wait memory, out_ready=1, rdata=addr^16'hA5A5 -> out_pc sequence 0,1,2,3,… one per cycle, each out_ir=pc^16'hA5A5.
- Backpressure: out_ready=0 for 6 cycles -> queue holds 2 entries (pc 0,1); imem_req drops; no ack lost. Resume -> pc 0,1,2 delivered in order, no duplicates.
- Redirect with 3-cycle-latency memory: br_taken=1, br_target=16'h0008 while the addr=2 request is outstanding -> addr 2 stays held; its response is dropped. Next request is addr 8; next out_pc=8.
- Redirect coincident with ack and with pop: br_taken, imem_ack, out_ready all high in one cycle -> that ack dropped, queue empty, next out_pc=br_target.
- Wrap and mid-operation reset: RESET_PC=16'hFFFE streams out_pc FFFE, FFFF, 0000. Asserting RSTN low mid-request -> imem_req=0 immediately; after release, fetch restarts at FFFE.
